// File: rtl/aes_stream_adapter_if.sv
// ============================================================================
// Module : aes_stream_adapter_if
// Brief  : Input/output word streams between the system bus and the adapter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface aes_stream_adapter_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_is_key;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    // master = word source / result sink, slave = adapter
    modport master (output s_valid, s_data, s_is_key, m_ready,
                    input  s_ready, m_valid, m_data);
    modport slave  (input  s_valid, s_data, s_is_key, m_ready,
                    output s_ready, m_valid, m_data);
endinterface

`default_nettype wire

// File: rtl/aes_stream_adapter.sv
// ============================================================================
// Module : aes_stream_adapter
// Brief  : Word-serial key/data loader and result unloader around an AES core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_stream_adapter #(
    parameter int TIMEOUT = 64
) (
    input  wire           clk,
    input  wire           rst_n,
    aes_stream_adapter_if.slave bus,
    output logic [127:0]  o_core_data_in,
    output logic [127:0]  o_core_key,
    output logic          o_core_rst_n,
    input  wire  [127:0]  i_core_result,
    input  wire           i_core_finished,
    output logic          o_busy,
    output logic          o_timeout_err
);

    localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_CYC_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_data;
    logic [127:0]   r_key;
    logic [127:0]   r_result;
    logic [2:0]     r_data_cnt;
    logic [1:0]     r_key_cnt;
    logic           r_key_loaded;
    logic [CW-1:0]  r_cyc_cnt;
    logic [1:0]     r_out_cnt;
    logic           r_core_rst_n;

    logic           w_s_ready;
    logic           w_data_fire;
    logic           w_key_fire;
    logic [2:0]     w_data_cnt_nxt;
    logic           w_key_loaded_nxt;
    logic           w_finish;
    logic           w_timeout;
    logic           w_m_valid;
    logic [31:0]    w_m_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_s_ready        = 1'b0;
        w_data_fire      = 1'b0;
        w_key_fire       = 1'b0;
        w_data_cnt_nxt   = r_data_cnt;
        w_key_loaded_nxt = r_key_loaded;
        w_finish         = 1'b0;
        w_timeout        = 1'b0;
        w_m_valid        = 1'b0;
        w_m_data         = 32'd0;
        case (r_state)
            S_LOAD: begin
                // rst_n gate keeps s_ready low while the reset is held
                w_s_ready   = rst_n && (bus.s_is_key || (r_data_cnt < 3'd4));
                w_data_fire = bus.s_valid && w_s_ready && !bus.s_is_key;
                w_key_fire  = bus.s_valid && w_s_ready && bus.s_is_key;
                if (w_data_fire) w_data_cnt_nxt = r_data_cnt + 3'd1;
                if (w_key_fire) begin
                    if (r_key_cnt == 2'd3)      w_key_loaded_nxt = 1'b1;
                    else if (r_key_cnt == 2'd0) w_key_loaded_nxt = 1'b0;
                end
                if ((w_data_cnt_nxt == 3'd4) && w_key_loaded_nxt) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_finish  = i_core_finished && (r_cyc_cnt != '0);
                w_timeout = !w_finish && (r_cyc_cnt == C_CYC_LAST);
                if (w_finish)       w_state_nxt = S_DRAIN;
                else if (w_timeout) w_state_nxt = S_LOAD;
            end
            S_DRAIN: begin
                w_m_valid = 1'b1;
                case (r_out_cnt)
                    2'd0:    w_m_data = r_result[127:96];
                    2'd1:    w_m_data = r_result[95:64];
                    2'd2:    w_m_data = r_result[63:32];
                    default: w_m_data = r_result[31:0];
                endcase
                if (bus.m_ready && (r_out_cnt == 2'd3)) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_key        <= '0;
            r_result     <= '0;
            r_data_cnt   <= 3'd0;
            r_key_cnt    <= 2'd0;
            r_key_loaded <= 1'b0;
            r_cyc_cnt    <= '0;
            r_out_cnt    <= 2'd0;
            r_core_rst_n <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_data_fire && (r_data_cnt[1:0] == 2'(i)))
                            r_data[96-32*i +: 32] <= bus.s_data;
                        if (w_key_fire && (r_key_cnt == 2'(i)))
                            r_key[96-32*i +: 32] <= bus.s_data;
                    end
                    if (w_key_fire) r_key_cnt <= r_key_cnt + 2'd1;
                    r_key_loaded <= w_key_loaded_nxt;
                    if (w_state_nxt == S_RUN) begin
                        r_data_cnt   <= 3'd0;
                        r_cyc_cnt    <= '0;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_data_cnt   <= w_data_cnt_nxt;
                    end
                end
                S_RUN: begin
                    if (w_finish) begin
                        r_result     <= i_core_result;
                        r_core_rst_n <= 1'b0;
                        r_out_cnt    <= 2'd0;
                    end else if (w_timeout) begin
                        r_core_rst_n <= 1'b0;
                    end else begin
                        r_cyc_cnt    <= r_cyc_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.m_ready) r_out_cnt <= r_out_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.m_valid    = w_m_valid;
    assign bus.m_data     = w_m_data;
    assign o_core_data_in = r_data;
    assign o_core_key     = r_key;
    assign o_core_rst_n   = r_core_rst_n;
    assign o_busy         = (r_state != S_LOAD);
    assign o_timeout_err  = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_aes_stream_adapter.sv
// ============================================================================
// Module : tb_aes_stream_adapter
// Brief  : Self-checking bench: block table, scoreboard, corner-case sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_stream_adapter;

    localparam logic [127:0] C_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_K2       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_D1       = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_D2       = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] C_D3       = 128'hffffffff00000000a5a5a5a55a5a5a5a;

    typedef struct packed {
        logic         load_key;
        logic         data_first;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid_a [2];
    logic         s_is_key_a[2];
    logic [31:0]  s_data_a  [2];
    logic         m_ready_a [2];
    logic         s_ready_a [2];
    logic         m_valid_a [2];
    logic [31:0]  m_data_a  [2];
    logic [127:0] core_din_a[2];
    logic [127:0] core_key_a[2];
    logic [127:0] core_res_a[2];
    logic         core_rst_n_a[2];
    logic         core_fin_a[2];
    logic         busy_a[2];
    logic         tmo_a[2];
    bit           hang[2];
    int           lat[2];

    logic [31:0]  sbq[2][$];
    int           checks = 0;
    int           errors = 0;
    int           rx_cnt[2];
    bit           prev_stall[2];
    logic [31:0]  prev_data[2];
    logic [31:0]  mon_exp;
    vec_t         vecs[4];

    always #5 clk = ~clk;

    aes_stream_adapter_if bus0 ();
    aes_stream_adapter_if bus1 ();

    assign bus0.s_valid  = s_valid_a[0];
    assign bus0.s_is_key = s_is_key_a[0];
    assign bus0.s_data   = s_data_a[0];
    assign bus0.m_ready  = m_ready_a[0];
    assign s_ready_a[0]  = bus0.s_ready;
    assign m_valid_a[0]  = bus0.m_valid;
    assign m_data_a[0]   = bus0.m_data;
    assign bus1.s_valid  = s_valid_a[1];
    assign bus1.s_is_key = s_is_key_a[1];
    assign bus1.s_data   = s_data_a[1];
    assign bus1.m_ready  = m_ready_a[1];
    assign s_ready_a[1]  = bus1.s_ready;
    assign m_valid_a[1]  = bus1.m_valid;
    assign m_data_a[1]   = bus1.m_data;

    aes_stream_adapter #(.TIMEOUT(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .o_core_data_in(core_din_a[0]), .o_core_key(core_key_a[0]),
        .o_core_rst_n(core_rst_n_a[0]), .i_core_result(core_res_a[0]),
        .i_core_finished(core_fin_a[0]), .o_busy(busy_a[0]), .o_timeout_err(tmo_a[0])
    );

    aes_stream_adapter #(.TIMEOUT(8)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .o_core_data_in(core_din_a[1]), .o_core_key(core_key_a[1]),
        .o_core_rst_n(core_rst_n_a[1]), .i_core_result(core_res_a[1]),
        .i_core_finished(core_fin_a[1]), .o_busy(busy_a[1]), .o_timeout_err(tmo_a[1])
    );

    // Stand-in core: FIPS-197 vector is exact, other blocks use a keyed mix
    function automatic logic [127:0] core_func(input logic [127:0] d, input logic [127:0] k);
        if (d == C_FIPS_PT && k == C_FIPS_KEY) return C_FIPS_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_core
        int ccnt;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)                ccnt <= 0;
            else if (!core_rst_n_a[u]) ccnt <= 0;
            else if (ccnt < 1000)      ccnt <= ccnt + 1;
        end
        assign core_fin_a[u] = !hang[u] && core_rst_n_a[u] && (ccnt >= lat[u]);
        assign core_res_a[u] = core_func(core_din_a[u], core_key_a[u]);
    end

    // Scoreboard pop, output hold and core_rst_n-only-in-RUN checks
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n) begin
                if (m_valid_a[u] && m_ready_a[u]) begin
                    checks++;
                    rx_cnt[u]++;
                    if (sbq[u].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word u%0d: got %h want none", u, m_data_a[u]);
                    end else begin
                        mon_exp = sbq[u].pop_front();
                        if (m_data_a[u] !== mon_exp) begin
                            errors++;
                            $display("FAIL m_data u%0d: got %h want %h", u, m_data_a[u], mon_exp);
                        end
                    end
                end
                if (prev_stall[u]) begin
                    checks++;
                    if (!m_valid_a[u] || m_data_a[u] !== prev_data[u]) begin
                        errors++;
                        $display("FAIL hold u%0d: got %b/%h want 1/%h", u, m_valid_a[u], m_data_a[u], prev_data[u]);
                    end
                end
                checks++;
                if (core_rst_n_a[u] !== (busy_a[u] && !m_valid_a[u])) begin
                    errors++;
                    $display("FAIL core_rst_n_run u%0d: got %b want %b", u, core_rst_n_a[u], busy_a[u] && !m_valid_a[u]);
                end
                prev_stall[u] = m_valid_a[u] && !m_ready_a[u];
                prev_data[u]  = m_data_a[u];
            end else begin
                prev_stall[u] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1
    task automatic send_word(input int u, input logic k, input logic [31:0] d);
        bit acc = 1'b0;
        int n = 0;
        s_valid_a[u] = 1'b1; s_is_key_a[u] = k; s_data_a[u] = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_ready_a[u];
            @(posedge clk);
            #1;
            n++;
        end
        s_valid_a[u] = 1'b0; s_is_key_a[u] = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout u%0d: got no s_ready want accept of %h", u, d);
        end
    endtask

    task automatic send_block(input int u, input logic k, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) send_word(u, k, blk[127-32*i -: 32]);
    endtask

    task automatic push_exp(input int u, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) sbq[u].push_back(blk[127-32*i -: 32]);
    endtask

    task automatic wait_drain(input int u);
        int  t = 0;
        bit  done = 1'b0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
            if (sbq[u].size() == 0 && !busy_a[u]) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout u%0d: got %0d pending want 0", u, sbq[u].size());
        end
        realign();
    endtask

    task automatic run_block(input int u, input vec_t v);
        logic [31:0] w[8];
        logic        k[8];
        int          n = 0;
        if (v.load_key && !v.data_first)
            for (int i = 0; i < 4; i++) begin w[n] = v.key[127-32*i -: 32]; k[n] = 1'b1; n++; end
        for (int i = 0; i < 4; i++) begin w[n] = v.data[127-32*i -: 32]; k[n] = 1'b0; n++; end
        if (v.load_key && v.data_first)
            for (int i = 0; i < 4; i++) begin w[n] = v.key[127-32*i -: 32]; k[n] = 1'b1; n++; end
        push_exp(u, v.exp);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                @(negedge clk);
                chk("idle_before_last", {127'd0, busy_a[u]}, 128'd0);
                realign();
            end
            send_word(u, k[i], w[i]);
            if (v.data_first && v.load_key && i == 3) begin
                s_valid_a[u] = 1'b1; s_is_key_a[u] = 1'b0;
                @(negedge clk);
                chk("s_ready_data_full", {127'd0, s_ready_a[u]}, 128'd0);
                s_is_key_a[u] = 1'b1;
                #1;
                chk("s_ready_key_open", {127'd0, s_ready_a[u]}, 128'd1);
                s_valid_a[u] = 1'b0; s_is_key_a[u] = 1'b0;
                realign();
            end
        end
        @(negedge clk);
        chk("run_busy", {127'd0, busy_a[u]}, 128'd1);
        chk("run_core_rst_n", {127'd0, core_rst_n_a[u]}, 128'd1);
        chk("run_core_data_in", core_din_a[u], v.data);
        chk("run_core_key", core_key_a[u], v.key);
        realign();
        wait_drain(u);
    endtask

    initial begin
        int          t;
        int          pulses;
        int          at;
        int          seen;
        int          rx0;
        bit          found;
        logic [127:0] bp_exp;

        vecs[0] = '{load_key: 1'b1, data_first: 1'b1, key: C_FIPS_KEY, data: C_FIPS_PT, exp: C_FIPS_CT};
        vecs[1] = '{load_key: 1'b0, data_first: 1'b0, key: C_FIPS_KEY, data: C_D1, exp: core_func(C_D1, C_FIPS_KEY)};
        vecs[2] = '{load_key: 1'b1, data_first: 1'b0, key: C_K2, data: C_D2, exp: core_func(C_D2, C_K2)};
        vecs[3] = '{load_key: 1'b0, data_first: 1'b0, key: C_K2, data: C_D3, exp: core_func(C_D3, C_K2)};

        for (int u = 0; u < 2; u++) begin
            s_valid_a[u] = 1'b0; s_is_key_a[u] = 1'b0; s_data_a[u] = 32'd0;
            m_ready_a[u] = 1'b1; hang[u] = 1'b0; lat[u] = 10; rx_cnt[u] = 0;
        end
        lat[1] = 3;
        rst_n = 1'b0;
        s_is_key_a[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", {127'd0, s_ready_a[0]}, 128'd0);
        chk("rst_m_valid", {127'd0, m_valid_a[0]}, 128'd0);
        chk("rst_m_data", {96'd0, m_data_a[0]}, 128'd0);
        chk("rst_core_data_in", core_din_a[0], 128'd0);
        chk("rst_core_key", core_key_a[0], 128'd0);
        chk("rst_core_rst_n", {127'd0, core_rst_n_a[0]}, 128'd0);
        chk("rst_busy", {127'd0, busy_a[0]}, 128'd0);
        chk("rst_timeout_err", {127'd0, tmo_a[0]}, 128'd0);
        chk("rst_busy_to", {127'd0, busy_a[1]}, 128'd0);
        realign();
        s_is_key_a[0] = 1'b0;
        rst_n = 1'b1;
        realign();

        for (int i = 0; i < 4; i++) run_block(0, vecs[i]);

        // Backpressure: stall five cycles on word 1 with the retained K2
        bp_exp = core_func(C_D1, C_K2);
        rx0 = rx_cnt[0];
        push_exp(0, bp_exp);
        send_block(0, 1'b0, C_D1);
        t = 0; found = 1'b0;
        while (!found && t < 100) begin
            @(negedge clk);
            t++;
            if (m_valid_a[0]) found = 1'b1;
        end
        chk("bp_word0_seen", {127'd0, found}, 128'd1);
        realign();
        m_ready_a[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_word1", {95'd0, m_valid_a[0], m_data_a[0]}, {95'd0, 1'b1, bp_exp[95:64]});
        end
        realign();
        m_ready_a[0] = 1'b1;
        wait_drain(0);
        chk("bp_word_count", 128'(rx_cnt[0] - rx0), 128'd4);

        // Asynchronous reset after two DRAIN words
        push_exp(0, core_func(C_D2, C_K2));
        send_block(0, 1'b0, C_D2);
        t = 0; seen = 0;
        while (seen < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (m_valid_a[0] && m_ready_a[0]) seen++;
        end
        chk("rd_two_words", 128'(seen), 128'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rd_m_valid", {127'd0, m_valid_a[0]}, 128'd0);
        chk("rd_busy", {127'd0, busy_a[0]}, 128'd0);
        chk("rd_core_rst_n", {127'd0, core_rst_n_a[0]}, 128'd0);
        chk("rd_pending", 128'(sbq[0].size()), 128'd2);
        sbq[0].delete();
        realign();
        realign();
        rst_n = 1'b1;
        realign();
        send_block(0, 1'b0, C_FIPS_PT);
        repeat (4) @(negedge clk);
        chk("rd_key_lost_idle", {127'd0, busy_a[0]}, 128'd0);
        chk("rd_data_full", {127'd0, s_ready_a[0]}, 128'd0);
        realign();
        push_exp(0, C_FIPS_CT);
        send_block(0, 1'b1, C_FIPS_KEY);
        @(negedge clk);
        chk("rd_reload_run", {127'd0, busy_a[0]}, 128'd1);
        realign();
        wait_drain(0);

        // Timeout on the TIMEOUT=8 instance, core never finishes
        hang[1] = 1'b1;
        send_block(1, 1'b1, C_K2);
        send_block(1, 1'b0, C_D2);
        pulses = 0; at = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tmo_a[1]) begin pulses++; at = c; end
        end
        chk("to_pulse_count", 128'(pulses), 128'd1);
        chk("to_pulse_cycle", 128'(at), 128'd7);
        chk("to_busy", {127'd0, busy_a[1]}, 128'd0);
        chk("to_core_rst_n", {127'd0, core_rst_n_a[1]}, 128'd0);
        chk("to_s_ready_data", {127'd0, s_ready_a[1]}, 128'd1);
        realign();
        hang[1] = 1'b0;
        push_exp(1, core_func(C_D3, C_K2));
        send_block(1, 1'b0, C_D3);
        @(negedge clk);
        chk("to_kept_key_run", {127'd0, busy_a[1]}, 128'd1);
        realign();
        wait_drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
